// File: rtl/seq_detect_ctrl_pkg.sv
// Shared types and helpers for the programmable serial-pattern detector.
package seq_detect_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int DEF_MAX_LEN = 8;
  localparam int DEF_CNT_W   = 8;

  // A zero length would make every bit a match, so it is promoted to 1.
  function automatic int clamp_len(input int len, input int max_len);
    if (len < 1) return 1;
    if (len > max_len) return max_len;
    return len;
  endfunction

endpackage

// File: rtl/seq_detect_ctrl_if.sv
// Host-side bundle of the detector: configuration handshake, control pulses,
// qualified serial stream and status outputs.
interface seq_detect_ctrl_if
  import seq_detect_ctrl_pkg::*;
#(
  parameter int MAX_LEN = DEF_MAX_LEN,
  parameter int CNT_W   = DEF_CNT_W
);
  localparam int LEN_W = $clog2(MAX_LEN + 1);

  logic               cfg_valid;
  logic               cfg_ready;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic               cfg_overlap;
  logic [CNT_W-1:0]   cfg_thresh;
  logic               start;
  logic               stop;
  logic               bit_valid;
  logic               bit_in;
  logic               match;
  logic [CNT_W-1:0]   match_cnt;
  logic               busy;
  logic               done;
  logic               timeout;

  modport master (
    output cfg_valid, cfg_pattern, cfg_len, cfg_overlap, cfg_thresh,
    output start, stop, bit_valid, bit_in,
    input  cfg_ready, match, match_cnt, busy, done, timeout
  );

  modport slave (
    input  cfg_valid, cfg_pattern, cfg_len, cfg_overlap, cfg_thresh,
    input  start, stop, bit_valid, bit_in,
    output cfg_ready, match, match_cnt, busy, done, timeout
  );

endinterface

// File: rtl/seq_window_cmp.sv
// Shift window with fill tracking; hit_o is evaluated on the post-shift window
// so the owner can register it as a match pulse.
module seq_window_cmp #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               shift_en_i,
  input  logic               clr_i,
  input  logic               fill_clr_i,
  input  logic               no_overlap_i,
  input  logic               bit_i,
  input  logic [MAX_LEN-1:0] pattern_i,
  input  logic [LEN_W-1:0]   len_i,
  output logic               hit_o
);

  logic [MAX_LEN-1:0] window_q, window_d;
  logic [MAX_LEN-1:0] shifted;
  logic [MAX_LEN-1:0] mask;
  logic [LEN_W-1:0]   fill_q, fill_d;
  logic [LEN_W-1:0]   fill_inc;

  for (genvar gi = 0; gi < MAX_LEN; gi++) begin : g_mask
    assign mask[gi] = (LEN_W'(gi) < len_i);
  end

  assign shifted = {window_q[MAX_LEN-2:0], bit_i};

  always_comb begin
    window_d = window_q;
    fill_d   = fill_q;
    hit_o    = 1'b0;
    fill_inc = (fill_q >= LEN_W'(MAX_LEN)) ? fill_q : fill_q + LEN_W'(1);
    if (clr_i) begin
      window_d = '0;
      fill_d   = '0;
    end else if (fill_clr_i) begin
      fill_d = '0;
    end else if (shift_en_i) begin
      window_d = shifted;
      hit_o    = (fill_inc >= len_i) && (((shifted ^ pattern_i) & mask) == '0);
      // Without overlap the matched bits must not contribute to the next match.
      fill_d   = (hit_o && no_overlap_i) ? '0 : fill_inc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      window_q <= '0;
      fill_q   <= '0;
    end else begin
      window_q <= window_d;
      fill_q   <= fill_d;
    end
  end

endmodule

// File: rtl/seq_detect_ctrl.sv
// Programmable serial-pattern detection controller (IDLE/RUN/DONE sequencer).
// Optional inter-bit gap timeout is built when SEQ_DETECT_CTRL_TIMEOUT_EN is defined.
module seq_detect_ctrl
  import seq_detect_ctrl_pkg::*;
#(
  parameter int MAX_LEN = DEF_MAX_LEN,
  parameter int CNT_W   = DEF_CNT_W
`ifdef SEQ_DETECT_CTRL_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYC = 255
`endif
) (
  input logic              clk,
  input logic              rst_n,
  seq_detect_ctrl_if.slave bus
);

  localparam int LEN_W = $clog2(MAX_LEN + 1);

  state_e             state_q;
  logic [MAX_LEN-1:0] pattern_q;
  logic [LEN_W-1:0]   len_q;
  logic               overlap_q;
  logic [CNT_W-1:0]   thresh_q;
  logic               match_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   cnt_inc;
  logic               busy_q;
  logic               done_q;
  logic               cfg_ready_q;
  logic               timeout_q;

  logic enter_run;
  logic shift_en;
  logic hit;
  logic to_fire;

  assign enter_run = bus.start && !bus.stop && (state_q != ST_RUN);
  assign shift_en  = (state_q == ST_RUN) && bus.bit_valid;
  assign cnt_inc   = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);

`ifdef SEQ_DETECT_CTRL_TIMEOUT_EN
  localparam int GAP_W = $clog2(TIMEOUT_CYC + 1);
  logic [GAP_W-1:0] gap_q;

  assign to_fire = (state_q == ST_RUN) && !bus.bit_valid &&
                   (gap_q == GAP_W'(TIMEOUT_CYC - 1));

  // Restarts after each firing so a long silence pulses repeatedly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gap_q <= '0;
    end else if (enter_run || bus.bit_valid || to_fire || state_q != ST_RUN) begin
      gap_q <= '0;
    end else begin
      gap_q <= gap_q + GAP_W'(1);
    end
  end
`else
  assign to_fire = 1'b0;
`endif

  seq_window_cmp #(
    .MAX_LEN (MAX_LEN),
    .LEN_W   (LEN_W)
  ) u_win (
    .clk          (clk),
    .rst_n        (rst_n),
    .shift_en_i   (shift_en),
    .clr_i        (enter_run),
    .fill_clr_i   (to_fire),
    .no_overlap_i (!overlap_q),
    .bit_i        (bus.bit_in),
    .pattern_i    (pattern_q),
    .len_i        (len_q),
    .hit_o        (hit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      pattern_q   <= '0;
      len_q       <= '0;
      overlap_q   <= 1'b0;
      thresh_q    <= '0;
      match_q     <= 1'b0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cfg_ready_q <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      match_q   <= 1'b0;
      timeout_q <= to_fire;
      case (state_q)
        ST_IDLE: begin
          if (bus.cfg_valid && cfg_ready_q) begin
            pattern_q <= bus.cfg_pattern;
            len_q     <= LEN_W'(clamp_len(int'(bus.cfg_len), MAX_LEN));
            overlap_q <= bus.cfg_overlap;
            thresh_q  <= bus.cfg_thresh;
          end
          if (enter_run) begin
            state_q     <= ST_RUN;
            cnt_q       <= '0;
            busy_q      <= 1'b1;
            cfg_ready_q <= 1'b0;
          end else begin
            cfg_ready_q <= 1'b1;
          end
        end
        ST_RUN: begin
          if (bus.stop) begin
            state_q     <= ST_IDLE;
            busy_q      <= 1'b0;
            cfg_ready_q <= 1'b1;
          end else if (hit) begin
            match_q <= 1'b1;
            cnt_q   <= cnt_inc;
            if (thresh_q != '0 && cnt_inc == thresh_q) begin
              state_q <= ST_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          if (bus.stop) begin
            state_q     <= ST_IDLE;
            done_q      <= 1'b0;
            cfg_ready_q <= 1'b1;
          end else if (enter_run) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          busy_q      <= 1'b0;
          done_q      <= 1'b0;
          cfg_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.cfg_ready = cfg_ready_q;
  assign bus.match     = match_q;
  assign bus.match_cnt = cnt_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.timeout   = timeout_q;

endmodule

// File: doc/seq_detect_ctrl.md
Name: seq_detect_ctrl

Overview:
- Programmable serial-pattern detection controller.
- Accepts a pattern configuration through a valid/ready handshake and is started and stopped by a host.
- Scans a qualified serial bit stream, counts matches, and flags completion when the match count reaches a programmed threshold.
- Generalises the fixed "101" Mealy detector into a configurable, sequenced resource that host logic can arm and re-arm.

Parameters:
- MAX_LEN, 8, maximum pattern length in bits (2..16).
- CNT_W, 8, width of the match counter and threshold.
- LEN_W, $clog2(MAX_LEN+1), width of the length field (derived; not overridden).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- cfg_valid  in  1  configuration offer
- cfg_ready  out  1  configuration accepted when high with cfg_valid
- cfg_pattern  in  MAX_LEN  pattern; bit len-1 is the first-expected bit, bit 0 the last
- cfg_len  in  LEN_W  pattern length
- cfg_overlap  in  1  1 = overlapping matches allowed
- cfg_thresh  in  CNT_W  match count that ends the run; 0 = never ends
- start  in  1  single-cycle pulse: arm detection
- stop  in  1  single-cycle pulse: abort to idle
- bit_valid  in  1  bit_in qualifier
- bit_in  in  1  serial data
- match  out  1  one-cycle pulse per detected match
- match_cnt  out  CNT_W  matches in current run
- busy  out  1  high in RUN
- done  out  1  high in DONE
- timeout  out  1  see Optional Feature

Behaviour:
- Reset (async, rst_n=0): state=IDLE, config registers=0, window=0, fill=0, match=0, match_cnt=0, busy=0, done=0, timeout=0, cfg_ready=1 after reset release.
- States:
  - IDLE: cfg_ready=1. cfg_valid&cfg_ready latches cfg_* in one cycle. start moves to RUN; entry clears window, fill and match_cnt.
  - RUN: busy=1. On bit_valid: window <= {window[MAX_LEN-2:0], bit_in} and fill <= min(fill+1, MAX_LEN). A hit requires fill (post-update) >= len and the low len bits of window (post-update) to equal the low len bits of pattern. match is registered and asserts the cycle after the completing bit is accepted.
  - Hit handling: match_cnt increments, saturating at all-ones. If overlap=0, fill clears to 0. If thresh!=0 and the incremented count equals thresh, move to DONE.
  - DONE: done=1, match_cnt held, bits ignored. start re-enters RUN with clears. stop moves to IDLE.
- stop in RUN or DONE goes to IDLE; match_cnt is retained until the next start.
- start and stop in the same cycle: stop wins.
- cfg_ready=0 outside IDLE; cfg_valid is ignored there.
- Length clamp at latch time: cfg_len=0 latches as 1; cfg_len>MAX_LEN latches as MAX_LEN.
- start in RUN is ignored.
- Reset asserted mid-run returns to the reset values immediately.

Optional Feature:
- Macro: SEQ_DETECT_CTRL_TIMEOUT_EN.
- With the macro:
  - Adds parameter TIMEOUT_CYC (default 255).
  - A gap counter clears on each bit_valid and on RUN entry.
  - When the counter reaches TIMEOUT_CYC in RUN, fill clears and timeout pulses for one cycle.
  - State stays RUN and match_cnt is unchanged.
- Without the macro: timeout is tied to 0 and no counter is built.

Decomposition:
- Package seq_detect_ctrl_pkg:
  - state enum: IDLE, RUN, DONE
  - default MAX_LEN and CNT_W constants
  - length-clamp function
- Sub-module seq_window_cmp:
  - shift window, fill counter, masked compare
  - inputs: shift enable, clear, bit, pattern, len
  - output: hit

Test Plan:
- Config pattern=3'b101, len=3, overlap=1, thresh=0; start; bits 1,0,1,0,1 -> match pulses one cycle after bits 3 and 5; match_cnt=2; busy stays 1.
- Same stream with overlap=0 -> single match after bit 3; match_cnt=1.
- thresh=2, overlap=1, stream 1,0,1,0,1,0,1 -> done=1 the cycle after bit 5; busy=0; further bits ignored; match_cnt stays 2.
- In RUN, cfg_valid=1 with new pattern -> cfg_ready=0 and config unchanged. stop+start in the same cycle -> IDLE. Then cfg_len=0 latches as 1; pattern bit0=1, stream 1,1 -> 2 matches.
- rst_n low for 1 cycle mid-run after bits 1,0 -> all outputs 0, state IDLE. Subsequent start with 1 ignored for lack of the earlier bits -> no match.
- With SEQ_DETECT_CTRL_TIMEOUT_EN and TIMEOUT_CYC=4: bits 1,0, then 4 idle cycles -> timeout pulse. Then bit 1 -> no match; bits 0,1 follow -> match.
